// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared FSM state and requester encodings for the mem_seq byte-memory sequencer
package mem_seq_pkg;
    typedef enum logic [1:0] {IDLE, HI, LO, ACK} state_t;
    typedef enum logic {FETCH, DATA} req_id_t;

    function automatic logic [15:0] next_addr(input logic [15:0] a);
        return a + 16'd1;
    endfunction
endpackage

// File: rtl/mem_seq_arb.sv
// mem_seq_arb: data-over-fetch arbitration with a saturating starvation counter for fetch
module mem_seq_arb
    import mem_seq_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    f_req,
    input  logic    d_req,
    input  logic    grant,
    output req_id_t win
);
    localparam int CW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;
    logic starved;

    always_comb begin
        starved = cnt == LIMIT;
        win = (f_req && (!d_req || starved)) ? FETCH : DATA;
    end

    // counts only data grants that made a waiting fetch wait longer
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (grant)
            cnt <= (win == DATA && f_req) ? (starved ? cnt : cnt + CW'(1)) : '0;
    end
endmodule

// File: rtl/mem_seq.sv
// mem_seq: sequences fetch/data requests of byte or 16-bit big-endian width onto an 8-bit memory port
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic        f_wide,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_wide,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);
    state_t      state;
    req_id_t     win, who;
    logic        we, wide;
    logic [15:0] addr;
    logic [7:0]  wlo, hi;
    logic        any, grant, g_data, g_we, g_wide, fin;
    logic [15:0] g_addr, res;

    always_comb begin
        any = f_req | d_req;
        grant = state == IDLE && any;
        g_data = win == DATA;
        g_we = g_data & d_we;
        g_wide = g_data ? d_wide : f_wide;
        g_addr = g_data ? d_addr : f_addr;
        fin = (state == HI && !wide) || state == LO;
        res = state == LO ? {hi, mem_rdata} : {8'h00, mem_rdata};
    end

    mem_seq_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk(clk),
        .reset(reset),
        .f_req(f_req),
        .d_req(d_req),
        .grant(grant),
        .win(win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            who <= FETCH;
            we <= 1'b0;
            wide <= 1'b0;
            addr <= '0;
            wlo <= '0;
            hi <= '0;
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            f_rdata <= '0;
            d_rdata <= '0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    state <= HI;
                    busy <= 1'b1;
                    who <= win;
                    we <= g_we;
                    wide <= g_wide;
                    addr <= g_addr;
                    wlo <= d_wdata[7:0];
                    mem_addr <= g_addr;
                    mem_rd <= !g_we;
                    mem_wr <= g_we;
                    mem_wdata <= g_wide ? d_wdata[15:8] : d_wdata[7:0];
                end
                HI: begin
                    hi <= mem_rdata;
                    state <= wide ? LO : ACK;
                    if (wide) begin
                        mem_addr <= next_addr(addr);
                        mem_rd <= !we;
                        mem_wr <= we;
                        mem_wdata <= wlo;
                    end
                end
                LO: state <= ACK;
                ACK: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
            // results land together with the ack so rdata is valid in the ACK cycle
            if (fin) begin
                f_ack <= who == FETCH;
                d_ack <= who == DATA;
                if (!we && who == FETCH) f_rdata <= res;
                if (!we && who == DATA) d_rdata <= res;
            end
        end
    end
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed vector table plus starvation and reset-abort sequences against a byte memory model
module tb_mem_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_wide, f_ack;
    logic [15:0] f_addr, f_rdata;
    logic        d_req, d_we, d_wide, d_ack;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr, busy;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [65536];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fetch;
        logic        we;
        logic        wide;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [7:0]  pre_hi;
        logic [7:0]  pre_lo;
        logic [7:0]  m_hi;
        logic [7:0]  m_lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    mem_seq #(.STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .f_req(f_req),
        .f_wide(f_wide),
        .f_addr(f_addr),
        .f_ack(f_ack),
        .f_rdata(f_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_wide(d_wide),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("strobe exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (f_ack || d_ack) chk("strobes idle at ack", {30'd0, mem_rd, mem_wr}, 32'd0);
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [15:0] a1, ma1, ma2, other, rd;
        logic        fa, da;
        int          lat;
        a1 = v.addr + 16'd1;
        poke(v.addr, v.pre_hi);
        poke(a1, v.pre_lo);
        other = v.fetch ? d_rdata : f_rdata;
        if (v.fetch) begin
            f_req = 1'b1; f_wide = v.wide; f_addr = v.addr;
            d_we = 1'b1; d_wdata = 16'hDEAD;
        end else begin
            d_req = 1'b1; d_we = v.we; d_wide = v.wide; d_addr = v.addr; d_wdata = v.wdata;
        end
        lat = -1; ma1 = '0; ma2 = '0; fa = 1'b0; da = 1'b0; rd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) ma1 = mem_addr;
            if (k == 2) ma2 = mem_addr;
            if (f_ack || d_ack) begin
                lat = k; fa = f_ack; da = d_ack;
                rd = v.fetch ? f_rdata : d_rdata;
                break;
            end
        end
        @(posedge clk);
        #1 f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " ack"}, {30'd0, fa, da}, v.fetch ? 32'd2 : 32'd1);
        chk({tag, " first addr"}, {16'd0, ma1}, {16'd0, v.addr});
        if (v.wide) chk({tag, " second addr"}, {16'd0, ma2}, {16'd0, a1});
        if (!v.we) chk({tag, " rdata"}, {16'd0, rd}, {16'd0, v.rdata});
        chk({tag, " other rdata held"}, {16'd0, v.fetch ? d_rdata : f_rdata}, {16'd0, other});
        chk({tag, " mem hi"}, {24'd0, mem[v.addr]}, {24'd0, v.m_hi});
        chk({tag, " mem lo"}, {24'd0, mem[a1]}, {24'd0, v.m_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        string      order;
        int         n;
        logic [7:0] got;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0086, 8'h86, 8'h11, 8'h86, 8'h11, 2};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 8'h12, 8'h34, 8'h12, 8'h34, 3};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h2000, 16'hBEEF, 16'h0000, 8'h00, 8'h00, 8'hBE, 8'hEF, 3};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h3000, 16'h12A5, 16'h0000, 8'h00, 8'h77, 8'hA5, 8'h77, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h00C3, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 2};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h5000, 16'h0000, 16'hCAFE, 8'hCA, 8'hFE, 8'hCA, 8'hFE, 3};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h00FF, 8'h00, 8'hFF, 8'h00, 8'hFF, 3};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h6000, 16'h0000, 16'h0000, 8'h00, 8'h99, 8'h00, 8'h99, 2};

        // reset held with a pending data request: nothing may start
        reset = 1'b1;
        f_req = 1'b0; f_wide = 1'b0; f_addr = '0;
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 16'h0100; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctl outputs", {27'd0, f_ack, d_ack, mem_rd, mem_wr, busy}, 32'd0);
        chk("reset mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("reset rdata", {f_rdata, d_rdata}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; d_req = 1'b0;

        for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // both requesters held: fetch gets in after STARVE_LIMIT data grants
        order = "DDDDFDDDDF";
        n = 0;
        f_wide = 1'b0; f_addr = 16'h0100;
        d_we = 1'b0; d_wide = 1'b0; d_addr = 16'h4000;
        f_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (f_ack || d_ack) begin
                got = f_ack ? "F" : "D";
                chk($sformatf("grant order %0d", n), {24'd0, got}, {24'd0, order[n]});
                n++;
            end
        end
        if (n < 10) chk("grant order timeout", n, 10);
        @(posedge clk);
        #1 f_req = 1'b0; d_req = 1'b0;

        // reset during LO of a wide read aborts it without an ack
        poke(16'h1234, 8'hAB);
        poke(16'h1235, 8'hCD);
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 16'h1234;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort busy in LO", {31'd0, busy}, 32'd1);
        chk("abort no ack in LO", {31'd0, d_ack}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("abort idle", {31'd0, busy}, 32'd0);
        chk("abort no ack", {30'd0, f_ack, d_ack}, 32'd0);
        chk("abort rdata cleared", {16'd0, d_rdata}, 32'd0);
        @(posedge clk);
        #1;
        apply('{1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0086, 8'h86, 8'h11, 8'h86, 8'h11, 2}, "fresh read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
